// File: rtl/rc4_pkg.sv
// rtl/rc4_pkg.sv - shared types and constants for the RC4 S-box block.
package rc4_pkg;

  localparam int SBOX_DEPTH = 256;

  typedef logic [7:0] byte_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    KSA   = 2'd2,
    READY = 2'd3
  } sbox_state_t;

endpackage

// File: rtl/rc4_sbox.sv
// rtl/rc4_sbox.sv - RC4 state array: identity fill, key scheduling, then
// three zero-latency read ports and a swap port for the keystream generator.
module rc4_sbox
  import rc4_pkg::*;
#(
  parameter int KEY_BYTES = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [8*KEY_BYTES-1:0] key,
  input  logic [7:0]             S_addr_a,
  input  logic [7:0]             S_addr_b,
  input  logic [7:0]             S_addr_c,
  input  logic                   S_swap,
  output logic [7:0]             S_data_a,
  output logic [7:0]             S_data_b,
  output logic [7:0]             S_data_c,
  output logic                   busy,
  output logic                   ready
);

  localparam byte_t KIDX_LAST = 8'(KEY_BYTES - 1);

  sbox_state_t state, state_next;

  byte_t                   i, j, kidx;
  logic [8*KEY_BYTES-1:0]  key_q;
  byte_t                   sbox [SBOX_DEPTH];
  byte_t                   s_i, key_byte, jn;

  assign S_data_a = sbox[S_addr_a];
  assign S_data_b = sbox[S_addr_b];
  assign S_data_c = sbox[S_addr_c];

  assign s_i = sbox[i];
  assign jn  = j + s_i + key_byte;

  // Key byte mux walks the latched key with kidx; no divider needed.
  always_comb begin
    key_byte = '0;
    for (int k = 0; k < KEY_BYTES; k++) begin
      if (kidx == 8'(k)) key_byte = key_q[8*k +: 8];
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = FILL;
      FILL:    if (i == 8'hFF) state_next = KSA;
      KSA:     if (i == 8'hFF) state_next = READY;
      READY:   if (start) state_next = FILL;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      i     <= '0;
      j     <= '0;
      kidx  <= '0;
      key_q <= '0;
      busy  <= 1'b0;
      ready <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next == FILL) || (state_next == KSA);
      ready <= (state_next == READY);
      case (state)
        IDLE, READY: begin
          if (start) begin
            key_q <= key;
            i     <= '0;
          end
        end
        FILL: begin
          i <= i + 8'd1;
          if (i == 8'hFF) begin
            j    <= '0;
            kidx <= '0;
          end
        end
        KSA: begin
          i    <= i + 8'd1;
          j    <= jn;
          kidx <= (kidx == KIDX_LAST) ? 8'd0 : kidx + 8'd1;
        end
        default: ;
      endcase
    end
  end

  // Array is deliberately not reset; its contents are meaningless until KSA ends.
  always_ff @(posedge clk) begin
    case (state)
      FILL: sbox[i] <= i;
      KSA: begin
        sbox[i]  <= sbox[jn];
        sbox[jn] <= s_i;
      end
      READY: begin
        if (S_swap) begin
          sbox[S_addr_a] <= S_data_b;
          sbox[S_addr_b] <= S_data_a;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rc4_sbox.sv
// tb/tb_rc4_sbox.sv - randomized self-checking bench for rc4_sbox with a
// behavioural RC4 model and an in-bench keystream generator.
module tb_rc4_sbox;
  import rc4_pkg::*;

  localparam logic [31:0] KEY_STR  = 32'h0079654B;
  localparam logic [31:0] WIKI_STR = 32'h696B6957;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start3 = 1'b0, start4 = 1'b0;
  logic        swap3 = 1'b0, swap4 = 1'b0;
  logic [23:0] key3 = '0;
  logic [31:0] key4 = '0;
  logic [7:0]  addr_a = '0, addr_b = '0, addr_c = '0;
  logic [7:0]  da3, db3, dc3, da4, db4, dc4;
  logic        busy3, ready3, busy4, ready4;

  int errors = 0;
  int checks = 0;

  byte_t ms [2][256];
  byte_t mi [2], mj [2], gi [2], gj [2];

  byte_t key_exp [10] = '{8'hEB, 8'h9F, 8'h77, 8'h81, 8'hB7, 8'h34, 8'hCA, 8'h72, 8'hA7, 8'h19};
  byte_t wiki_exp [6] = '{8'h60, 8'h44, 8'hDB, 8'h6D, 8'h41, 8'hB7};

  always #5 clk = ~clk;

  rc4_sbox #(.KEY_BYTES(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .key(key3),
    .S_addr_a(addr_a), .S_addr_b(addr_b), .S_addr_c(addr_c), .S_swap(swap3),
    .S_data_a(da3), .S_data_b(db3), .S_data_c(dc3), .busy(busy3), .ready(ready3)
  );

  rc4_sbox #(.KEY_BYTES(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .key(key4),
    .S_addr_a(addr_a), .S_addr_b(addr_b), .S_addr_c(addr_c), .S_swap(swap4),
    .S_data_a(da4), .S_data_b(db4), .S_data_c(dc4), .busy(busy4), .ready(ready4)
  );

  function automatic byte_t rd_a(input int sel);
    return (sel == 0) ? da3 : da4;
  endfunction
  function automatic byte_t rd_b(input int sel);
    return (sel == 0) ? db3 : db4;
  endfunction
  function automatic byte_t rd_c(input int sel);
    return (sel == 0) ? dc3 : dc4;
  endfunction
  function automatic logic rd_busy(input int sel);
    return (sel == 0) ? busy3 : busy4;
  endfunction
  function automatic logic rd_ready(input int sel);
    return (sel == 0) ? ready3 : ready4;
  endfunction

  task automatic set_swap(input int sel, input logic v);
    if (sel == 0) swap3 = v; else swap4 = v;
  endtask

  task automatic set_start(input int sel, input logic v);
    if (sel == 0) start3 = v; else start4 = v;
  endtask

  // Reference RC4 key schedule from the textbook definition.
  task automatic model_init(input int sel, input logic [31:0] kv);
    int    len;
    byte_t jj, t, kb;
    len = (sel == 0) ? 3 : 4;
    for (int n = 0; n < 256; n++) ms[sel][n] = byte_t'(n);
    jj = 0;
    for (int n = 0; n < 256; n++) begin
      kb = kv[8*(n % len) +: 8];
      jj = jj + ms[sel][n] + kb;
      t = ms[sel][n]; ms[sel][n] = ms[sel][jj]; ms[sel][jj] = t;
    end
    mi[sel] = 0; mj[sel] = 0; gi[sel] = 0; gj[sel] = 0;
  endtask

  task automatic model_prga(input int sel, output byte_t out);
    byte_t t, idx;
    mi[sel] = mi[sel] + 8'd1;
    mj[sel] = mj[sel] + ms[sel][mi[sel]];
    t = ms[sel][mi[sel]]; ms[sel][mi[sel]] = ms[sel][mj[sel]]; ms[sel][mj[sel]] = t;
    idx = ms[sel][mi[sel]] + ms[sel][mj[sel]];
    out = ms[sel][idx];
  endtask

  task automatic model_swap(input int sel, input byte_t a, input byte_t b);
    byte_t t;
    t = ms[sel][a]; ms[sel][a] = ms[sel][b]; ms[sel][b] = t;
  endtask

  // Keystream generator built on the DUT ports: read i, read j, swap, read t next cycle.
  task automatic gen_byte(input int sel, output byte_t out);
    byte_t si, sj;
    @(negedge clk);
    gi[sel] = gi[sel] + 8'd1;
    addr_a = gi[sel];
    #1 si = rd_a(sel);
    gj[sel] = gj[sel] + si;
    addr_b = gj[sel];
    #1 sj = rd_b(sel);
    addr_c = si + sj;
    set_swap(sel, 1'b1);
    @(posedge clk);
    #1 set_swap(sel, 1'b0);
    out = rd_c(sel);
  endtask

  task automatic init_dut(input int sel, input logic [31:0] kv, input bit poke_start, input bit poke_swap);
    int bad_k;
    bad_k = -1;
    @(negedge clk);
    if (sel == 0) key3 = kv[23:0]; else key4 = kv;
    set_start(sel, 1'b1);
    @(posedge clk);
    #1;
    checks++;
    if (rd_busy(sel) !== 1'b1 || rd_ready(sel) !== 1'b0) begin
      errors++;
      $display("FAIL start_edge dut%0d: busy=%b ready=%b expected busy=1 ready=0", sel, rd_busy(sel), rd_ready(sel));
    end
    for (int k = 1; k <= 512; k++) begin
      @(negedge clk);
      set_start(sel, poke_start && (k == 100));
      if (k == 1) begin
        if (sel == 0) key3 = $urandom; else key4 = $urandom;
      end
      if (poke_swap && k >= 5 && k <= 511) begin
        set_swap(sel, 1'b1);
        addr_a = $urandom; addr_b = $urandom;
      end else begin
        set_swap(sel, 1'b0);
      end
      @(posedge clk);
      #1;
      if (k < 512 && (rd_busy(sel) !== 1'b1 || rd_ready(sel) !== 1'b0) && bad_k < 0) bad_k = k;
      if (k == 512) begin
        checks++;
        if (rd_busy(sel) !== 1'b0 || rd_ready(sel) !== 1'b1) begin
          errors++;
          $display("FAIL ready_at_512 dut%0d: busy=%b ready=%b expected busy=0 ready=1", sel, rd_busy(sel), rd_ready(sel));
        end
      end
    end
    checks++;
    if (bad_k >= 0) begin
      errors++;
      $display("FAIL busy_window dut%0d: busy/ready wrong at E0+%0d expected busy=1 ready=0", sel, bad_k);
    end
    @(negedge clk);
    set_start(sel, 1'b0);
    set_swap(sel, 1'b0);
    model_init(sel, kv);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy3 !== 1'b0 || ready3 !== 1'b0 || busy4 !== 1'b0 || ready4 !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: busy3=%b ready3=%b busy4=%b ready4=%b expected all 0", busy3, ready3, busy4, ready4);
    end
    @(negedge clk);
    rst = 1'b0;
    key3 = KEY_STR[23:0];
    start3 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start3 = 1'b0;
    repeat (300) @(posedge clk);
    #1;
    checks++;
    if (busy3 !== 1'b1) begin
      errors++;
      $display("FAIL busy_mid_ksa: busy=%b expected 1", busy3);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (busy3 !== 1'b0 || ready3 !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_abort: busy=%b ready=%b expected busy=0 ready=0", busy3, ready3);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (busy3 !== 1'b0 || ready3 !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%b ready=%b expected busy=0 ready=0", busy3, ready3);
    end
  endtask

  task automatic test_ksa_vector();
    byte_t got, exp;
    init_dut(0, KEY_STR, 1'b0, 1'b0);
    for (int n = 0; n < 10; n++) begin
      gen_byte(0, got);
      model_prga(0, exp);
      checks++;
      if (got !== key_exp[n]) begin
        errors++;
        $display("FAIL key_vector[%0d]: got %h expected %h", n, got, key_exp[n]);
      end
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL key_model[%0d]: got %h expected %h", n, got, exp);
      end
    end
  endtask

  task automatic test_wiki_vector();
    byte_t got;
    init_dut(1, WIKI_STR, 1'b0, 1'b0);
    for (int n = 0; n < 6; n++) begin
      gen_byte(1, got);
      checks++;
      if (got !== wiki_exp[n]) begin
        errors++;
        $display("FAIL wiki_vector[%0d]: got %h expected %h", n, got, wiki_exp[n]);
      end
    end
    for (int n = 0; n < 6; n++) begin
      byte_t e;
      model_prga(1, e);
    end
  endtask

  task automatic test_array_contents(input int sel);
    for (int n = 0; n < 256; n++) begin
      @(negedge clk);
      addr_c = byte_t'(n);
      #1;
      checks++;
      if (rd_c(sel) !== ms[sel][n]) begin
        errors++;
        $display("FAIL array_dut%0d[%0d]: got %h expected %h", sel, n, rd_c(sel), ms[sel][n]);
      end
    end
  endtask

  task automatic test_swap();
    byte_t va, vb, a, b;
    @(negedge clk);
    addr_a = 8'd3; addr_b = 8'd200;
    #1 va = da3; vb = db3;
    swap3 = 1'b1;
    @(posedge clk);
    #1 swap3 = 1'b0;
    model_swap(0, 8'd3, 8'd200);
    checks++;
    if (da3 !== vb || db3 !== va) begin
      errors++;
      $display("FAIL swap_3_200: got a=%h b=%h expected a=%h b=%h", da3, db3, vb, va);
    end
    checks++;
    if (da3 !== ms[0][3]) begin
      errors++;
      $display("FAIL swap_3_model: got %h expected %h", da3, ms[0][3]);
    end
    @(negedge clk);
    addr_a = 8'd77; addr_b = 8'd77;
    #1 va = da3;
    swap3 = 1'b1;
    @(posedge clk);
    #1 swap3 = 1'b0;
    checks++;
    if (da3 !== va || da3 !== ms[0][77]) begin
      errors++;
      $display("FAIL swap_same_addr: got %h expected %h", da3, ms[0][77]);
    end
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      a = $urandom; b = $urandom;
      addr_a = a; addr_b = b;
      swap3 = 1'b1;
      @(posedge clk);
      #1 swap3 = 1'b0;
      model_swap(0, a, b);
      checks++;
      if (da3 !== ms[0][a] || db3 !== ms[0][b]) begin
        errors++;
        $display("FAIL swap_rand[%0d] %h/%h: got %h/%h expected %h/%h", n, a, b, da3, db3, ms[0][a], ms[0][b]);
      end
    end
  endtask

  task automatic test_ignored_inputs();
    byte_t got;
    init_dut(0, KEY_STR, 1'b1, 1'b1);
    for (int n = 0; n < 10; n++) begin
      gen_byte(0, got);
      checks++;
      if (got !== key_exp[n]) begin
        errors++;
        $display("FAIL ignored_key_vector[%0d]: got %h expected %h", n, got, key_exp[n]);
      end
    end
    for (int n = 0; n < 10; n++) begin
      byte_t e;
      model_prga(0, e);
    end
  endtask

  task automatic test_restart(input int sel);
    logic [31:0] kv;
    byte_t       got, exp;
    kv = $urandom;
    if (sel == 0) kv[31:24] = 8'h00;
    checks++;
    if (rd_ready(sel) !== 1'b1) begin
      errors++;
      $display("FAIL restart_pre_ready dut%0d: ready=%b expected 1", sel, rd_ready(sel));
    end
    init_dut(sel, kv, 1'b0, 1'b0);
    for (int n = 0; n < 16; n++) begin
      gen_byte(sel, got);
      model_prga(sel, exp);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL restart_dut%0d[%0d] key=%h: got %h expected %h", sel, n, kv, got, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ksa_vector();
    test_array_contents(0);
    test_wiki_vector();
    test_array_contents(1);
    test_swap();
    test_array_contents(0);
    test_ignored_inputs();
    test_restart(1);
    test_array_contents(1);
    test_restart(0);
    test_restart(1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
